// File: rtl/router_fsm_ctrl.sv
// Packet sequencer for the 1x3 router: decodes the header address, steps header/payload/parity into one FIFO, and runs per-FIFO read watchdogs.
// Latency: state and all outputs are registered; outputs change one clock after the inputs that cause them.
// Backpressure: busy stalls the source; fifo_full parks the FSM in FIFO_FULL_STATE with write_enb low until space frees.
module router_fsm_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic [2:0] soft_reset,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           nxt_state;
    logic [1:0]       addr_reg;
    logic [1:0]       nxt_addr;
    logic [CNT_W-1:0] cnt [3];
    logic             nxt_wr;

    // Next-state and next-address decode; a watchdog reset on the active FIFO aborts the packet.
    always_comb begin
        nxt_state = state;
        nxt_addr  = addr_reg;
        if (soft_reset[addr_reg]) begin
            nxt_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && (data_in != 2'b11)) begin
                        nxt_addr  = data_in;
                        nxt_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (fifo_empty[addr_reg]) nxt_state = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: nxt_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full[addr_reg])  nxt_state = FIFO_FULL_STATE;
                    else if (!pkt_valid)      nxt_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full[addr_reg]) nxt_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)          nxt_state = DECODE_ADDRESS;
                    else if (low_pkt_valid)   nxt_state = LOAD_PARITY;
                    else                      nxt_state = LOAD_DATA;
                end
                LOAD_PARITY: nxt_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    nxt_state = fifo_full[addr_reg] ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: nxt_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Which states write into the selected FIFO.
    always_comb begin
        nxt_wr = (nxt_state == LOAD_DATA) || (nxt_state == LOAD_AFTER_FULL) ||
                 (nxt_state == LOAD_PARITY);
    end

    // State register with Moore outputs registered from the next state, so they match the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= DECODE_ADDRESS;
            addr_reg    <= 2'b00;
            write_enb   <= 3'b000;
            detect_add  <= 1'b1;
            lfd_state   <= 1'b0;
            ld_state    <= 1'b0;
            laf_state   <= 1'b0;
            full_state  <= 1'b0;
            rst_int_reg <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            addr_reg    <= nxt_addr;
            write_enb   <= nxt_wr ? 3'(3'b001 << nxt_addr) : 3'b000;
            detect_add  <= (nxt_state == DECODE_ADDRESS);
            lfd_state   <= (nxt_state == LOAD_FIRST_DATA);
            ld_state    <= (nxt_state == LOAD_DATA);
            laf_state   <= (nxt_state == LOAD_AFTER_FULL);
            full_state  <= (nxt_state == FIFO_FULL_STATE);
            rst_int_reg <= (nxt_state == CHECK_PARITY_ERROR);
            busy        <= !((nxt_state == DECODE_ADDRESS) || (nxt_state == LOAD_DATA));
        end
    end

    // Per-FIFO read watchdog: pulse soft_reset once after TIMEOUT consecutive unread, non-empty cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            soft_reset <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (cnt[i] == TO_LAST) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt[i]        <= cnt[i] + 1'b1;
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl: stimulus pushes the hand-computed output vector expected after each edge,
// and a monitor pops and compares at the falling edge of that cycle.
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic [2:0] soft_reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;

    router_fsm_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb(write_enb), .soft_reset(soft_reset), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // Expected-output bit layout: {write_enb[2:0], soft_reset[2:0], detect, lfd, ld, laf, full, rst_int, busy}
    localparam int DA = 0, WTE = 1, LFD = 2, LD = 3, FFS = 4, LAF = 5, LP = 6, CPE = 7;

    function automatic logic [12:0] ex(input int st, input int a, input logic [2:0] sr);
        logic [2:0] we;
        logic [6:0] f;
        we = 3'b000;
        case (st)
            DA:  f = 7'b1000000;
            WTE: f = 7'b0000001;
            LFD: f = 7'b0100001;
            LD:  begin f = 7'b0010000; we = (a == 0) ? 3'b001 : (a == 1) ? 3'b010 : 3'b100; end
            FFS: f = 7'b0000101;
            LAF: begin f = 7'b0001001; we = (a == 0) ? 3'b001 : (a == 1) ? 3'b010 : 3'b100; end
            LP:  begin f = 7'b0000001; we = (a == 0) ? 3'b001 : (a == 1) ? 3'b010 : 3'b100; end
            default: f = 7'b0000011;
        endcase
        return {we, sr, f};
    endfunction

    typedef struct {
        int          cyc;
        logic [12:0] ev;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    wire [12:0] act = {write_enb, soft_reset, detect_add, lfd_state, ld_state,
                       laf_state, full_state, rst_int_reg, busy};

    // Monitor: compare every expectation that belongs to the cycle just clocked.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || act !== e.ev) begin
                n_bad++;
                $display("FAIL %s cyc=%0d exp_cyc=%0d got=%b want=%b", e.tag, cyc, e.cyc, act, e.ev);
            end
        end
    end

    task automatic drv(input bit rst, input bit pv, input bit [1:0] din, input bit [2:0] fe,
                       input bit [2:0] ff, input bit [2:0] re, input bit pd, input bit lpv);
        reset = rst; pkt_valid = pv; data_in = din; fifo_empty = fe;
        fifo_full = ff; read_enb = re; parity_done = pd; low_pkt_valid = lpv;
    endtask

    task automatic step(input string tag, input logic [12:0] ev);
        exp_t e;
        e.cyc = cyc + 1;
        e.ev  = ev;
        e.tag = tag;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset held two cycles
        drv(1, 0, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("reset0", ex(DA, 0, 3'b000));
        step("reset1", ex(DA, 0, 3'b000));

        // 2: packet to FIFO1, 14 payload beats, parity, check
        drv(0, 1, 2'b01, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t2_lfd", ex(LFD, 1, 3'b000));
        for (int k = 0; k < 14; k++) step("t2_ld", ex(LD, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t2_lp", ex(LP, 1, 3'b000));
        step("t2_cpe", ex(CPE, 1, 3'b000));
        step("t2_da", ex(DA, 1, 3'b000));

        // 3: FIFO2 busy -> wait until empty
        drv(0, 1, 2'b10, 3'b011, 3'b000, 3'b111, 0, 0);
        step("t3_wte", ex(WTE, 2, 3'b000));
        drv(0, 0, 2'b00, 3'b011, 3'b000, 3'b111, 0, 0);
        for (int k = 0; k < 3; k++) step("t3_wait", ex(WTE, 2, 3'b000));
        drv(0, 1, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t3_lfd", ex(LFD, 2, 3'b000));
        step("t3_ld", ex(LD, 2, 3'b000));
        drv(0, 0, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t3_lp", ex(LP, 2, 3'b000));
        step("t3_cpe", ex(CPE, 2, 3'b000));
        step("t3_da", ex(DA, 2, 3'b000));

        // 4: full back-pressure on FIFO1 (full beats pkt_valid low), then recovery paths
        drv(0, 1, 2'b01, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t4_lfd", ex(LFD, 1, 3'b000));
        step("t4_ld", ex(LD, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b010, 3'b111, 0, 0);
        step("t4_full_prio", ex(FFS, 1, 3'b000));
        step("t4_full_hold", ex(FFS, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b000, 3'b111, 0, 0);
        step("t4_laf", ex(LAF, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b000, 3'b111, 0, 1);
        step("t4_lp", ex(LP, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b010, 3'b111, 0, 0);
        step("t4_cpe", ex(CPE, 1, 3'b000));
        step("t4_cpe_full", ex(FFS, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b000, 3'b111, 0, 0);
        step("t4_laf2", ex(LAF, 1, 3'b000));
        drv(0, 0, 2'b00, 3'b101, 3'b000, 3'b111, 1, 0);
        step("t4_pdone", ex(DA, 1, 3'b000));

        // 5a: FIFO0 unread for 30 cycles while loading it -> one pulse, FSM aborts
        drv(0, 1, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t5_lfd", ex(LFD, 0, 3'b000));
        drv(0, 1, 2'b00, 3'b110, 3'b000, 3'b110, 0, 0);
        for (int k = 1; k <= 29; k++) step("t5_count", ex(LD, 0, 3'b000));
        step("t5_pulse", ex(LD, 0, 3'b001));
        step("t5_abort", ex(DA, 0, 3'b000));
        drv(0, 0, 2'b00, 3'b110, 3'b000, 3'b111, 0, 0);
        step("t5_clear", ex(DA, 0, 3'b000));

        // 5b: read on the 29th cycle -> no pulse
        drv(0, 0, 2'b00, 3'b110, 3'b000, 3'b110, 0, 0);
        for (int k = 1; k <= 28; k++) step("t5b_count", ex(DA, 0, 3'b000));
        drv(0, 0, 2'b00, 3'b110, 3'b000, 3'b111, 0, 0);
        step("t5b_read", ex(DA, 0, 3'b000));
        drv(0, 0, 2'b00, 3'b110, 3'b000, 3'b110, 0, 0);
        step("t5b_nopulse30", ex(DA, 0, 3'b000));
        step("t5b_nopulse31", ex(DA, 0, 3'b000));
        drv(0, 0, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t5b_idle", ex(DA, 0, 3'b000));

        // 6: address 11 dropped; reset from LOAD_DATA
        drv(0, 1, 2'b11, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t6_drop0", ex(DA, 0, 3'b000));
        step("t6_drop1", ex(DA, 0, 3'b000));
        drv(0, 1, 2'b10, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t6_lfd", ex(LFD, 2, 3'b000));
        step("t6_ld", ex(LD, 2, 3'b000));
        drv(1, 1, 2'b10, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t6_reset", ex(DA, 0, 3'b000));
        drv(0, 0, 2'b00, 3'b111, 3'b000, 3'b111, 0, 0);
        step("t6_idle", ex(DA, 0, 3'b000));

        // Drain: bounded wait for the monitor to consume everything
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clock);
        @(negedge clock);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
